serial_adder_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Adds two WIDTH-bit operands with one

---
 rtl/serial_adder_ctrl_if.sv | 42 ++++
 rtl/serial_adder_ctrl.sv | 174 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Request/result bundle for the bit-serial adder sequencer.
//   The requester side uses the master modport and the adder uses the slave modport.
//   Optional feature macro: SERIAL_ADD_SUB_EN. When it is defined, the bundle
//   also carries the subtract-select line "sub".
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    // Request side
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    // Result side
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder sequencer. It uses one full-adder cell and processes the
//   operands LSB first, one bit per clock. The carry between bits is held in a flop.
//   A request is accepted in IDLE or DONE. The sequencer then runs for WIDTH
//   cycles with busy high. It pulses done for one cycle with {cout,sum} = a + b + cin.
//   Optional feature macro: SERIAL_ADD_SUB_EN. When it is defined, sub=1 captures
//   ~b and forces the initial carry to 1, so the result is a - b.
//   In subtract mode, cout=1 means no borrow.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);

    // Counter width; WIDTH is legal over 2..32, so at least one bit is needed
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Single-bit full adder: returns {carry_out, sum_bit}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic s_bit;
        logic c_bit;
        s_bit = x ^ y ^ c;
        c_bit = (x & y) | (x & c) | (y & c);
        return {c_bit, s_bit};
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_fa;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_carry_cap;

    // Operand-capture values; in subtract mode B is inverted and the carry is seeded with 1
    always_comb begin
        w_b_cap     = bus.b;
        w_carry_cap = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            w_b_cap     = ~bus.b;
            w_carry_cap = 1'b1;
        end else begin
            w_b_cap     = bus.b;
            w_carry_cap = bus.cin;
        end
`endif
    end

    // The one full-adder cell working on the current LSBs and the held carry
    always_comb begin
        w_fa = full_add(r_a_sh[0], r_b_sh[0], r_carry);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and request acceptance; start during RUN is ignored
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_accept     = 1'b0;
            end
        endcase
    end

    // Datapath: capture on accept; in RUN, shift operands right, push sum bit in at the MSB, and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= w_b_cap;
            r_carry <= w_carry_cap;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= r_sum;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_fa[1];
            r_cnt   <= r_cnt + CNT_ONE;
            r_sum   <= {w_fa[0], r_sum[WIDTH-1:1]};
        end else begin
            r_a_sh  <= r_a_sh;
            r_b_sh  <= r_b_sh;
            r_carry <= r_carry;
            r_cnt   <= r_cnt;
            r_sum   <= r_sum;
        end
    end

    // Final carry is latched on the last RUN bit and held with sum afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout <= 1'b0;
        end else if ((r_state == ST_RUN) && (r_cnt == LAST_CNT)) begin
            r_cout <= w_fa[1];
        end else begin
            r_cout <= r_cout;
        end
    end

    // Registered status flags that track the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_RUN);
            r_done <= (w_next_state == ST_DONE);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (WIDTH=8). A transaction-level model
//   predicts busy, done, sum and cout every cycle. Directed vectors also pin
//   literal results, latencies and done counts.
//   Optional feature macro: SERIAL_ADD_SUB_EN (subtract vectors).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    int         m_left;    // RUN cycles still to go; 0 = not busy
    logic       m_done;
    logic       m_valid;   // sum/cout defined and checkable
    logic [W:0] m_pend;
    logic [W-1:0] m_sum;
    logic       m_cout;

    function automatic logic [W:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
        else   return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    logic sub_s;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_s = bus.sub;
`else
    assign sub_s = 1'b0;
`endif

    // Model update on each clock edge; asynchronous reset clears everything
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_valid <= 1'b1;
            m_pend  <= '0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_sum   <= m_pend[W-1:0];
                m_cout  <= m_pend[W];
                m_valid <= 1'b1;
            end
        end else if (bus.start) begin
            m_left  <= W;
            m_pend  <= model_result(bus.a, bus.b, bus.cin, sub_s);
            m_done  <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("busy", {31'd0, bus.busy}, {31'd0, (m_left != 0)});
        check("done", {31'd0, bus.done}, {31'd0, m_done});
        if (m_valid) begin
            check("sum",  {24'd0, bus.sum},  {24'd0, m_sum});
            check("cout", {31'd0, bus.cout}, {31'd0, m_cout});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c, input logic s);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.cin   = c;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("sub request ignored in add-only build");
`endif
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int nbusy;
        int ncyc;
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        @(negedge clk);
        #1 drive_start(x, y, c, s);
        for (ncyc = 1; ncyc <= 20; ncyc++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            #1 bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check({name, "_seen_done"}, {31'd0, seen}, 32'd1);
        check({name, "_latency"},   ncyc,  W + 1);
        check({name, "_busy_cycles"}, nbusy, W);
        check({name, "_sum"},  {24'd0, bus.sum},  {24'd0, exp_sum});
        check({name, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
    endtask

    initial begin
        int ndone;
        int gap;
        logic [W-1:0] got_sum;
        logic got_cout;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum",  {24'd0, bus.sum},  32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        #1 rst_n = 1'b1;

        run_op("add",   8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
        run_op("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("wrap2", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        run_op("cin1",  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0);

        // Busy guard: a second start mid-RUN must be ignored
        ndone    = 0;
        got_sum  = '0;
        got_cout = 1'b1;
        @(negedge clk);
        #1 drive_start(8'h01, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                got_sum  = bus.sum;
                got_cout = bus.cout;
            end
            #1;
            if (i == 3) drive_start(8'h80, 8'h80, 1'b0, 1'b0);
            else        bus.start = 1'b0;
        end
        check("guard_done_count", ndone, 1);
        check("guard_sum",  {24'd0, got_sum},  32'h02);
        check("guard_cout", {31'd0, got_cout}, 32'd0);

        // Back-to-back: start held in the DONE cycle
        run_op("b2b_first", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
        #1 drive_start(8'h10, 8'h20, 1'b0, 1'b0);
        gap = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                gap = i;
                break;
            end
            #1 bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("b2b_gap", gap, W + 1);
        check("b2b_sum", {24'd0, bus.sum}, 32'h30);
        check("b2b_cout", {31'd0, bus.cout}, 32'd0);

        // Mid-operation reset on the 4th RUN cycle
        @(negedge clk);
        #1 drive_start(8'hAA, 8'h55, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1 bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_sum",  {24'd0, bus.sum},  32'd0);
        check("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub2", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
        run_op("sub0", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
